// File: rtl/picomips_core_if.sv
// Instruction-memory fetch bus for picomips_core: a req/ack handshake carrying
// the fetch address out and the instruction word back.
interface picomips_core_if #(
    parameter int PC_WIDTH    = 5,
    parameter int INSTR_WIDTH = 17
);
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_ack;
    logic [INSTR_WIDTH-1:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/picomips_core.sv
// Multi-cycle SUBLEQ/MULTI core with req/ack instruction fetch and halt detection.
// Define PICOMIPS_SAT_EN to make both operations saturate instead of wrap.
module picomips_core #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 8,
    parameter int PC_WIDTH   = 5,
    parameter int IMM_WIDTH  = 5,
    parameter int IMM_FRAC   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    picomips_core_if.master       imem,
    input  logic [DATA_WIDTH-1:0] sw,
    output logic [DATA_WIDTH-1:0] led,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  halted
);
    localparam int RA = $clog2(NUM_REGS);
    localparam int IW = 1 + 2*RA + 2*PC_WIDTH;
    localparam int PW = DATA_WIDTH + IMM_WIDTH;

`ifdef PICOMIPS_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [IW-1:0]          ir_q, ir_d;
    logic [DATA_WIDTH-1:0]  a_q, a_d;
    logic [DATA_WIDTH-1:0]  b_q, b_d;
    logic                   req_q, req_d;
    logic                   halted_q, halted_d;
    logic [DATA_WIDTH-1:0]  regs_q [NUM_REGS];
    logic                   wr_en_s;

    logic                   op_s;
    logic [RA-1:0]          ra_s, rb_s;
    logic [PC_WIDTH-1:0]    br_s, nml_s, next_pc_s;
    logic [IMM_WIDTH-1:0]   imm_s;

    logic signed [DATA_WIDTH:0] diff_s;
    logic signed [PW-1:0]       prod_s, shr_s;
    logic                       sub_ovf_s, mul_ovf_s;
    logic [DATA_WIDTH-1:0]      res_s;
    logic                       take_s;

    assign op_s  = ir_q[IW-1];
    assign ra_s  = ir_q[IW-2 -: RA];
    assign rb_s  = ir_q[IW-2-RA -: RA];
    assign br_s  = ir_q[2*PC_WIDTH-1 -: PC_WIDTH];
    assign nml_s = ir_q[PC_WIDTH-1:0];
    assign imm_s = br_s[PC_WIDTH-1 -: IMM_WIDTH];

    // One extra bit on the difference exposes signed overflow as a sign mismatch.
    assign diff_s    = $signed({b_q[DATA_WIDTH-1], b_q}) - $signed({a_q[DATA_WIDTH-1], a_q});
    assign sub_ovf_s = diff_s[DATA_WIDTH] ^ diff_s[DATA_WIDTH-1];

    assign prod_s    = $signed({{IMM_WIDTH{a_q[DATA_WIDTH-1]}}, a_q})
                     * $signed({{DATA_WIDTH{imm_s[IMM_WIDTH-1]}}, imm_s});
    assign shr_s     = prod_s >>> IMM_FRAC;
    assign mul_ovf_s = (shr_s[PW-1:DATA_WIDTH-1] != {(PW-DATA_WIDTH+1){shr_s[PW-1]}});

    // Execute result and branch decision for the latched instruction.
    always_comb begin
        res_s  = {DATA_WIDTH{1'b0}};
        take_s = 1'b0;
        if (op_s == 1'b0) begin
            if (SAT_EN && sub_ovf_s) begin
                res_s = diff_s[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
            end else begin
                res_s = diff_s[DATA_WIDTH-1:0];
            end
            take_s = res_s[DATA_WIDTH-1] | (res_s == {DATA_WIDTH{1'b0}});
        end else begin
            if (SAT_EN && mul_ovf_s) begin
                res_s = shr_s[PW-1] ? SAT_MIN : SAT_MAX;
            end else begin
                res_s = shr_s[DATA_WIDTH-1:0];
            end
            take_s = 1'b0;
        end
    end

    assign next_pc_s = take_s ? br_s : nml_s;

    // Next-state logic for the fetch/decode/execute/halt sequence.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        halted_d = halted_q;
        wr_en_s  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                // req_q gates ack so a stale ack right after reset is ignored.
                if (req_q && imem.imem_ack) begin
                    ir_d    = imem.imem_data;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                a_d     = (ra_s == {RA{1'b0}}) ? sw : regs_q[ra_s];
                b_d     = (rb_s == {RA{1'b0}}) ? sw : regs_q[rb_s];
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                wr_en_s = (rb_s != {RA{1'b0}});
                if (next_pc_s == pc_q) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else begin
                    pc_d    = next_pc_s;
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
        req_d = (state_d == ST_FETCH);
    end

    // State, datapath latches and register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            pc_q     <= {PC_WIDTH{1'b0}};
            ir_q     <= {IW{1'b0}};
            a_q      <= {DATA_WIDTH{1'b0}};
            b_q      <= {DATA_WIDTH{1'b0}};
            req_q    <= 1'b0;
            halted_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            req_q    <= req_d;
            halted_q <= halted_d;
            if (wr_en_s) begin
                regs_q[rb_s] <= res_s;
            end
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign led            = regs_q[NUM_REGS-1];
    assign pc             = pc_q;
    assign halted         = halted_q;

endmodule

// File: tb/tb_picomips_core.sv
// Self-checking bench for picomips_core: directed vector table, randomized
// instructions against an integer reference model, reset and halt sequences.
module tb_picomips_core;
    localparam int DW  = 8;
    localparam int PCW = 5;
    localparam int IW  = 17;

    logic           clk = 1'b0;
    logic           reset;
    logic [DW-1:0]  sw;
    logic [DW-1:0]  led;
    logic [PCW-1:0] pc;
    logic           halted;

    picomips_core_if #(.PC_WIDTH(PCW), .INSTR_WIDTH(IW)) bus ();

    picomips_core dut (
        .clk    (clk),
        .reset  (reset),
        .imem   (bus),
        .sw     (sw),
        .led    (led),
        .pc     (pc),
        .halted (halted)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_regs [8];
    logic [4:0] m_pc;
    logic       m_halt;

    typedef struct {
        logic [16:0] w;
        logic [7:0]  swv;
        int          waits;
        logic [7:0]  exp_led;
        logic [4:0]  exp_pc;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] enc(input logic op, input logic [2:0] ra, input logic [2:0] rb,
                                        input logic [4:0] br, input logic [4:0] nml);
        return {op, ra, rb, br, nml};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_pc   = 5'd0;
        m_halt = 1'b0;
    endtask

    // Reference: signed integer arithmetic straight from the instruction rules.
    task automatic model_step(input logic [16:0] w, input logic [7:0] swv);
        int a, b, r, imm;
        logic [7:0] res8;
        logic       take;
        logic [2:0] ra, rb;
        logic [4:0] br, nml, nxt;
        ra  = w[15:13];
        rb  = w[12:10];
        br  = w[9:5];
        nml = w[4:0];
        if (ra == 3'd0) a = $signed(swv); else a = $signed(m_regs[ra]);
        if (rb == 3'd0) b = $signed(swv); else b = $signed(m_regs[rb]);
        if (w[16] == 1'b0) begin
            r = b - a;
        end else begin
            imm = $signed(br);
            r   = (a * imm) >>> 4;
        end
`ifdef PICOMIPS_SAT_EN
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
`endif
        res8 = r[7:0];
        take = (w[16] == 1'b0) && ($signed(res8) <= 0);
        if (rb != 3'd0) m_regs[rb] = res8;
        nxt = take ? br : nml;
        if (nxt == m_pc) m_halt = 1'b1;
        else m_pc = nxt;
    endtask

    // Serve one fetch with the given wait states; cyc counts cycles from the
    // first request cycle until the next request (or halt) is visible.
    task automatic exec_instr(input string tag, input logic [16:0] w, input logic [7:0] swv,
                              input int waits, output int cyc);
        int guard;
        logic [4:0] a0;
        cyc   = 0;
        sw    = swv;
        guard = 0;
        while (bus.imem_req !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, ":req_seen"}, 32'(bus.imem_req), 32'd1);
        a0 = bus.imem_addr;
        for (int i = 0; i < waits; i++) begin
            bus.imem_ack = 1'b0;
            @(negedge clk);
            cyc++;
            chk({tag, ":req_stable"}, 32'(bus.imem_req), 32'd1);
            chk({tag, ":addr_stable"}, 32'(bus.imem_addr), 32'(a0));
        end
        bus.imem_ack  = 1'b1;
        bus.imem_data = w;
        @(negedge clk);
        cyc++;
        bus.imem_ack  = 1'b0;
        bus.imem_data = 17'($urandom);
        chk({tag, ":req_drop"}, 32'(bus.imem_req), 32'd0);
        guard = 0;
        while (bus.imem_req !== 1'b1 && halted !== 1'b1 && guard < 40) begin
            @(negedge clk);
            cyc++;
            guard++;
        end
    endtask

    initial begin
        int cyc;
        logic [16:0] w;
        logic [7:0]  swv;
        logic [4:0]  br, nml;
        int          waits;

        tbl[0] = '{enc(1'b0, 3'd0, 3'd7, 5'd9, 5'd1),      8'h05, 0, 8'hFB, 5'd9};
        tbl[1] = '{enc(1'b0, 3'd0, 3'd7, 5'd9, 5'd1),      8'hF6, 0, 8'h05, 5'd1};
        tbl[2] = '{enc(1'b1, 3'd0, 3'd7, 5'b01000, 5'd2),  8'd64, 0, 8'd32, 5'd2};
        tbl[3] = '{enc(1'b1, 3'd0, 3'd7, 5'b11000, 5'd3),  8'd64, 0, 8'hE0, 5'd3};
        tbl[4] = '{enc(1'b0, 3'd0, 3'd0, 5'd4, 5'd5),      8'h33, 0, 8'hE0, 5'd4};
        tbl[5] = '{enc(1'b0, 3'd7, 3'd7, 5'd6, 5'd5),      8'h00, 3, 8'h00, 5'd6};
        tbl[6] = '{enc(1'b0, 3'd0, 3'd7, 5'd10, 5'd7),     8'h81, 1, 8'h7F, 5'd7};
`ifdef PICOMIPS_SAT_EN
        tbl[7] = '{enc(1'b0, 3'd0, 3'd7, 5'd12, 5'd8),     8'h80, 0, 8'h7F, 5'd8};
`else
        tbl[7] = '{enc(1'b0, 3'd0, 3'd7, 5'd12, 5'd8),     8'h80, 0, 8'hFF, 5'd12};
`endif

        // Reset held two cycles with a stale ack pending.
        reset         = 1'b1;
        sw            = 8'h00;
        bus.imem_ack  = 1'b1;
        bus.imem_data = 17'h1FFFF;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_req", 32'(bus.imem_req), 32'd1);
        chk("post_rst_addr", 32'(bus.imem_addr), 32'd0);
        bus.imem_ack = 1'b0;

        for (int i = 0; i < 8; i++) begin
            model_step(tbl[i].w, tbl[i].swv);
            exec_instr($sformatf("vec%0d", i), tbl[i].w, tbl[i].swv, tbl[i].waits, cyc);
            chk($sformatf("vec%0d_led", i), 32'(led), 32'(tbl[i].exp_led));
            chk($sformatf("vec%0d_pc", i), 32'(pc), 32'(tbl[i].exp_pc));
            chk($sformatf("vec%0d_addr", i), 32'(bus.imem_addr), 32'(tbl[i].exp_pc));
            chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(3 + tbl[i].waits));
            chk($sformatf("vec%0d_halted", i), 32'(halted), 32'd0);
        end

        // Random instructions; branch targets steered away from the current pc.
        for (int i = 0; i < 40; i++) begin
            br  = 5'($urandom);
            nml = 5'($urandom);
            if (br == m_pc) br = m_pc + 5'd1;
            if (nml == m_pc) nml = m_pc + 5'd2;
            w     = enc(1'($urandom), 3'($urandom), 3'($urandom), br, nml);
            swv   = 8'($urandom);
            waits = $urandom_range(0, 2);
            model_step(w, swv);
            exec_instr($sformatf("rnd%0d", i), w, swv, waits, cyc);
            chk($sformatf("rnd%0d_led", i), 32'(led), 32'(m_regs[7]));
            chk($sformatf("rnd%0d_pc", i), 32'(pc), 32'(m_pc));
            chk($sformatf("rnd%0d_cycles", i), 32'(cyc), 32'(3 + waits));
        end

        // Reset during a stalled fetch.
        bus.imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("stall_req", 32'(bus.imem_req), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("stall_rst_req", 32'(bus.imem_req), 32'd0);
        chk("stall_rst_pc", 32'(pc), 32'd0);
        chk("stall_rst_led", 32'(led), 32'd0);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        chk("stall_rel_req", 32'(bus.imem_req), 32'd1);
        chk("stall_rel_addr", 32'(bus.imem_addr), 32'd0);

        // Move to address 4, then an instruction whose next pc is itself.
        exec_instr("go4", enc(1'b1, 3'd0, 3'd1, 5'd0, 5'd4), 8'h10, 0, cyc);
        chk("go4_pc", 32'(pc), 32'd4);
        exec_instr("halt", enc(1'b1, 3'd0, 3'd7, 5'b01000, 5'd4), 8'h10, 2, cyc);
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_led", 32'(led), 32'h08);
        chk("halt_pc", 32'(pc), 32'd4);
        chk("halt_cycles", 32'(cyc), 32'd5);
        for (int i = 0; i < 20; i++) begin
            bus.imem_ack = 1'($urandom);
            sw = 8'($urandom);
            @(negedge clk);
            chk("halt_req_low", 32'(bus.imem_req), 32'd0);
            chk("halt_led_frozen", 32'(led), 32'h08);
            chk("halt_pc_frozen", 32'(pc), 32'd4);
            chk("halt_stays", 32'(halted), 32'd1);
        end

        // Reset is the only way out of halt.
        bus.imem_ack = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("unhalt_flag", 32'(halted), 32'd0);
        chk("unhalt_pc", 32'(pc), 32'd0);
        chk("unhalt_led", 32'(led), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("unhalt_req", 32'(bus.imem_req), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
